// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings,
// NZCV flag bit positions and the stage-0 carry selection helper.
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    function automatic logic op_inverts_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    function automatic logic op_carry0(input logic [1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry segment of the pipelined adder: a purely combinational
// SEG-bit add with carry-in and carry-out.
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] sum_o,
    output logic           c_o
);

    logic [SEG:0] total;

    assign total = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, c_i};
    assign {c_o, sum_o} = total;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract with NZCV flags and carry-in chaining; one carry
// segment per stage. Optional saturation is enabled by defining ADDSUB_SAT_EN.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
`ifdef ADDSUB_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_nzcv,
    output logic [TAG_W-1:0] out_tag
);

    // WIDTH must be a multiple of STAGES; each stage owns one SEG-bit slice.
    localparam int SEG = WIDTH / STAGES;
    localparam int PS  = (STAGES > 1) ? STAGES - 1 : 1;

    // Handshake: an op transfers on in_valid && in_ready; a result transfers on
    // out_valid && out_ready. The whole pipe moves together whenever the output
    // register is empty or being drained, otherwise everything holds.
    logic advance;

    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] r_in  [STAGES];
    logic [WIDTH-1:0] r_out [STAGES];
    logic             v_in  [STAGES];
    logic             c_in  [STAGES];
    logic [TAG_W-1:0] t_in  [STAGES];
    logic [SEG-1:0]   sum   [STAGES];
    logic             co    [STAGES];

    logic [WIDTH-1:0] a_q [PS];
    logic [WIDTH-1:0] b_q [PS];
    logic [WIDTH-1:0] r_q [PS];
    logic             v_q [PS];
    logic             c_q [PS];
    logic [TAG_W-1:0] t_q [PS];

    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic [3:0]       out_nzcv_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             a_msb;
    logic             b_msb;
    logic             ovf;
    logic [WIDTH-1:0] res_fin;
    logic [3:0]       nzcv_fin;

`ifdef ADDSUB_SAT_EN
    logic s_in [STAGES];
    logic s_q  [PS];
    assign s_in[0] = in_sat;
`endif

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    assign a_in[0] = in_a;
    assign b_in[0] = op_inverts_b(in_op) ? ~in_b : in_b;
    assign c_in[0] = op_carry0(in_op, in_cin);
    assign r_in[0] = '0;
    assign v_in[0] = in_valid;
    assign t_in[0] = in_tag;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_seg #(.SEG(SEG)) u_seg (
            .a_i  (a_in[k][k*SEG +: SEG]),
            .b_i  (b_in[k][k*SEG +: SEG]),
            .c_i  (c_in[k]),
            .sum_o(sum[k]),
            .c_o  (co[k])
        );
        if (k < STAGES - 1) begin : g_link
            assign a_in[k+1] = a_q[k];
            assign b_in[k+1] = b_q[k];
            assign r_in[k+1] = r_q[k];
            assign v_in[k+1] = v_q[k];
            assign c_in[k+1] = c_q[k];
            assign t_in[k+1] = t_q[k];
`ifdef ADDSUB_SAT_EN
            assign s_in[k+1] = s_q[k];
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            r_out[k] = r_in[k];
            r_out[k][k*SEG +: SEG] = sum[k];
        end
    end

    // Final stage: full result is aligned here, so flags come from it.
    always_comb begin
        a_msb   = a_in[STAGES-1][WIDTH-1];
        b_msb   = b_in[STAGES-1][WIDTH-1];
        res_fin = r_out[STAGES-1];
        ovf     = (a_msb == b_msb) && (res_fin[WIDTH-1] != a_msb);
`ifdef ADDSUB_SAT_EN
        if (s_in[STAGES-1] && ovf) begin
            res_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        nzcv_fin         = '0;
        nzcv_fin[NZCV_N] = res_fin[WIDTH-1];
        nzcv_fin[NZCV_Z] = (res_fin == '0);
        nzcv_fin[NZCV_C] = co[STAGES-1];
        nzcv_fin[NZCV_V] = ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                v_q[k] <= 1'b0;
            end
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_nzcv_q   <= '0;
            out_tag_q    <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                v_q[k] <= v_in[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                r_q[k] <= r_out[k];
                c_q[k] <= co[k];
                t_q[k] <= t_in[k];
`ifdef ADDSUB_SAT_EN
                s_q[k] <= s_in[k];
`endif
            end
            out_valid_q  <= v_in[STAGES-1];
            out_result_q <= res_fin;
            out_nzcv_q   <= nzcv_fin;
            out_tag_q    <= t_in[STAGES-1];
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_nzcv   = out_nzcv_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=32, STAGES=4); saturation
// vectors are included when ADDSUB_SAT_EN is defined.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int W = 32;
    localparam int S = 4;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic         in_cin;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [T-1:0] in_tag;
    logic         in_sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [3:0]   out_nzcv;
    logic [T-1:0] out_tag;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [T-1:0] exp_tag_q[$];

    int           mon_c;
    int           mon_got;
    logic         mon_stalled;
    logic [W-1:0] held_r;
    logic [T-1:0] held_t;
    logic         seen;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
`ifdef ADDSUB_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_nzcv  (out_nzcv),
        .out_tag   (out_tag)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [T-1:0] tag, input logic sat);
        in_op  = op;
        in_a   = a;
        in_b   = b;
        in_cin = cin;
        in_tag = tag;
        in_sat = sat;
    endtask

    task automatic send_one(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic [T-1:0] tag, input logic sat);
        @(negedge clk);
        drive(op, a, b, cin, tag, sat);
        in_valid = 1'b1;
        #1;
        chk("in_ready before send", {31'b0, in_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] exp_res,
                              input logic [3:0] exp_nzcv, input logic [T-1:0] exp_tag);
        int lat;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, S);
        chk({name, " result"}, out_result, exp_res);
        chk({name, " nzcv"}, {28'b0, out_nzcv}, {28'b0, exp_nzcv});
        chk({name, " tag"}, {28'b0, out_tag}, {28'b0, exp_tag});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(OP_ADD, '0, '0, 1'b0, '0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset out_valid", {31'b0, out_valid}, 0);
        chk("reset out_result", out_result, 0);
        chk("reset out_nzcv", {28'b0, out_nzcv}, 0);
        chk("reset out_tag", {28'b0, out_tag}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", {31'b0, in_ready}, 1);

        // Single operations with hand-computed results
        send_one(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'h1, 1'b0);
        expect_out("add_ovf", 32'h8000_0000, 4'b1001, 4'h1);
        send_one(OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 4'h2, 1'b0);
        expect_out("sub_zero", 32'h0000_0000, 4'b0110, 4'h2);
        send_one(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 4'h3, 1'b0);
        expect_out("sub_borrow", 32'hFFFF_FFFF, 4'b1000, 4'h3);
        send_one(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h4, 1'b0);
        expect_out("add_wrap", 32'h0000_0000, 4'b0110, 4'h4);
        send_one(OP_ADC, 32'h0000_0001, 32'h0000_0000, 1'b1, 4'h5, 1'b0);
        expect_out("adc_cin", 32'h0000_0002, 4'b0000, 4'h5);
        send_one(OP_SBC, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'h6, 1'b0);
        expect_out("sbc_nocin", 32'hFFFF_FFFF, 4'b1000, 4'h6);
        send_one(OP_ADD, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 4'h7, 1'b0);
        expect_out("add_segcarry", 32'h2222_2221, 4'b0000, 4'h7);
        send_one(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 4'h8, 1'b0);
        expect_out("sub_negovf", 32'h7FFF_FFFF, 4'b0011, 4'h8);

        // Backpressure: 8 back-to-back ops, out_ready low for 3 cycles mid-stream
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back((32'h1000_0000 * i + i) + 32'h0101_0101);
            exp_tag_q.push_back(T'(i));
        end
        mon_c       = 0;
        mon_got     = 0;
        mon_stalled = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int w;
                    @(negedge clk);
                    drive(OP_ADD, 32'h1000_0000 * i + i, 32'h0101_0101, 1'b0, T'(i), 1'b0);
                    in_valid = 1'b1;
                    #1;
                    w = 0;
                    while (!in_ready && w < 50) begin
                        @(negedge clk);
                        #1;
                        w++;
                    end
                    @(posedge clk);
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                while (mon_got < 8 && mon_c < 100) begin
                    @(negedge clk);
                    out_ready = !(mon_c >= 5 && mon_c < 8);
                    #1;
                    if (mon_stalled && out_valid) begin
                        chk("bp stall result stable", out_result, held_r);
                        chk("bp stall tag stable", {28'b0, out_tag}, {28'b0, held_t});
                    end
                    if (out_valid && !out_ready) begin
                        chk("bp in_ready low", {31'b0, in_ready}, 0);
                        mon_stalled = 1'b1;
                        held_r      = out_result;
                        held_t      = out_tag;
                    end else begin
                        mon_stalled = 1'b0;
                    end
                    if (out_valid && out_ready) begin
                        logic [W-1:0] er;
                        logic [T-1:0] et;
                        er = exp_q.pop_front();
                        et = exp_tag_q.pop_front();
                        chk("bp result", out_result, er);
                        chk("bp tag", {28'b0, out_tag}, {28'b0, et});
                        chk("bp nzcv", {28'b0, out_nzcv}, 0);
                        mon_got++;
                    end
                    mon_c++;
                end
                chk("bp results received", mon_got, 8);
            end
        join
        out_ready = 1'b1;
        @(negedge clk);

        // Reset with 3 ops in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(OP_ADD, 32'(i + 1), 32'h0, 1'b0, T'(8 + i), 1'b0);
            in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst out_valid", {31'b0, out_valid}, 0);
        chk("midrst out_result", out_result, 0);
        chk("midrst out_nzcv", {28'b0, out_nzcv}, 0);
        chk("midrst out_tag", {28'b0, out_tag}, 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst no stale output", {31'b0, seen}, 0);
        send_one(OP_ADD, 32'h0000_0003, 32'h0000_0004, 1'b0, 4'hC, 1'b0);
        expect_out("post_reset", 32'h0000_0007, 4'b0000, 4'hC);

`ifdef ADDSUB_SAT_EN
        send_one(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'hD, 1'b1);
        expect_out("sat_pos", 32'h7FFF_FFFF, 4'b0001, 4'hD);
        send_one(OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'hE, 1'b1);
        expect_out("sat_neg", 32'h8000_0000, 4'b1011, 4'hE);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
